// File: rtl/madd_err_accum.sv
// Error-metric accumulator for the 6x6+6 approximate multiply-add netlists.
// Recomputes exact = a*b+c for every accepted sample and folds approx-exact
// into run statistics (sample count, mismatch count, sum|err|, signed sum,
// max|err|) through a two-stage pipeline.
module madd_err_accum #(
   parameter int CNT_W = 20,
   parameter int SUM_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [5:0]       op_a,
   input  logic [5:0]       op_b,
   input  logic [5:0]       op_c,
   input  logic [11:0]      approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] n_samples,
   output logic [CNT_W-1:0] n_mismatch,
   output logic [SUM_W-1:0] sum_abs_err,
   output logic [SUM_W-1:0] sum_err,
   output logic [11:0]      max_abs_err
);

   // Wide enough that one 12-bit error can never overflow the accumulator
   // before the saturation check sees it.
   localparam int AW = SUM_W + 14;

   localparam logic signed [AW-1:0] ERR_MAX = {{(AW-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
   localparam logic signed [AW-1:0] ERR_MIN = {{(AW-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};
   localparam logic [AW-1:0]        ABS_MAX = {{(AW-SUM_W){1'b0}}, {SUM_W{1'b1}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic                 accept;
   logic [11:0]          prod;
   logic [12:0]          exact;
   logic signed [12:0]   diff;

   logic                 s1_valid;
   logic signed [12:0]   s1_diff;

   logic signed [12:0]   neg_diff;
   logic [11:0]          abs_diff;
   logic [AW-1:0]        sum_abs_wide;
   logic signed [AW-1:0] sum_err_wide;
   logic [SUM_W-1:0]     sum_abs_next;
   logic [SUM_W-1:0]     sum_err_next;

   // in_ready depends only on the state register, so there is no path from
   // in_valid. A start pulse takes priority over a coincident sample.
   assign in_ready = (state == RUN);
   assign busy     = (state == RUN) || (state == DRAIN);
   assign accept   = in_valid && in_ready && !start;

   assign prod  = {6'b0, op_a} * {6'b0, op_b};
   assign exact = {1'b0, prod} + {7'b0, op_c};
   assign diff  = $signed({1'b0, approx} - exact);

   // Next-state logic; start restarts the run from any state.
   always_comb begin
      next_state = state;
      if (start) begin
         next_state = RUN;
      end else begin
         case (state)
            IDLE:    next_state = IDLE;
            RUN:     if (accept && in_last) next_state = DRAIN;
            DRAIN:   if (!s1_valid) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

   // State register plus the one-cycle done pulse on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         done  <= (state == DRAIN) && (next_state == DONE);
      end
   end

   // Saturating next values for the two error sums, computed in a wider
   // domain and clamped back to SUM_W bits.
   always_comb begin
      neg_diff     = -s1_diff;
      abs_diff     = s1_diff[12] ? neg_diff[11:0] : s1_diff[11:0];
      sum_abs_wide = {{(AW-SUM_W){1'b0}}, sum_abs_err} + {{(AW-12){1'b0}}, abs_diff};
      sum_err_wide = $signed({{(AW-SUM_W){sum_err[SUM_W-1]}}, sum_err})
                   + $signed({{(AW-13){s1_diff[12]}}, s1_diff});
      sum_abs_next = sum_abs_wide[SUM_W-1:0];
      sum_err_next = sum_err_wide[SUM_W-1:0];
      if (sum_abs_wide > ABS_MAX) begin
         sum_abs_next = {SUM_W{1'b1}};
      end
      if (sum_err_wide > ERR_MAX) begin
         sum_err_next = {1'b0, {(SUM_W-1){1'b1}}};
      end else if (sum_err_wide < ERR_MIN) begin
         sum_err_next = {1'b1, {(SUM_W-1){1'b0}}};
      end
   end

   // Stage 1 captures the signed error of each accepted sample; start
   // flushes whatever is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
      end else if (start) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_diff <= diff;
         end
      end
   end

   // Stage 2 folds the stage-1 error into the statistics; start clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_samples   <= '0;
         n_mismatch  <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
         max_abs_err <= '0;
      end else if (start) begin
         n_samples   <= '0;
         n_mismatch  <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
         max_abs_err <= '0;
      end else if (s1_valid) begin
         if (n_samples != {CNT_W{1'b1}}) begin
            n_samples <= n_samples + 1'b1;
         end
         if ((s1_diff != 13'sd0) && (n_mismatch != {CNT_W{1'b1}})) begin
            n_mismatch <= n_mismatch + 1'b1;
         end
         sum_abs_err <= sum_abs_next;
         sum_err     <= sum_err_next;
         if (abs_diff > max_abs_err) begin
            max_abs_err <= abs_diff;
         end
      end
   end

endmodule
